ram16x8_master: RTL and testbench

Initiator for the 16x8 synchronous RAM: the controller that drives `cs`/`w_en`/`op_en`/address/data and captures the RAM's registered read data. Upstream logic issues single-beat read/write requests over a valid/ready handshake. Read data is returned over a valid/ready response channel. The block also performs a 16-address clear sweep after reset and on command, because the RAM's own reset does not clear the array.

---
 rtl/ram16x8_pkg.sv | 19 +
 rtl/ram16x8_master.sv | 169 ++++++++++++++++
 tb/tb_ram16x8_master.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram16x8_pkg.sv
// ram16x8_pkg: shared sizes and FSM state encoding for the 16x8 RAM initiator.
//   ADDR_W / DATA_W / DEPTH   geometry of the attached RAM
//   ram_mst_state_t           bus phase of ram16x8_master
package ram16x8_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    READ,
    RWAIT,
    RESP
  } ram_mst_state_t;

endpackage

// File: rtl/ram16x8_master.sv
// ram16x8_master: initiator for the 16x8 synchronous RAM.
//   Single-beat read/write requests arrive over a valid/ready handshake. Read data
//   is returned over a valid/ready response channel. A 16-address clear sweep runs
//   after reset (AUTO_INIT=1) and on init_start, because the RAM's own reset does
//   not clear its array.
// Ports:
//   clk, reset_n (async, active-low)
//   req_valid/req_ready/req_write/req_addr/req_wdata   request channel
//   rsp_valid/rsp_ready/rsp_rdata                      response channel
//   init_start (sampled only in IDLE), init_busy       clear sweep
//   mem_cs/mem_w_en/mem_op_en/mem_addr/mem_wdata       registered RAM controls
//   mem_rdata                                          RAM data_out (registered in RAM)
module ram16x8_master
  import ram16x8_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VALUE = 8'h00,
  parameter bit                AUTO_INIT  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_start,
  output logic              init_busy,
  output logic              mem_cs,
  output logic              mem_w_en,
  output logic              mem_op_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  ram_mst_state_t    state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic              w_en_q, w_en_d;
  logic              op_en_q, op_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              idle_q, idle_d;
  logic              busy_q, busy_d;
  logic              accept;

  // idle_q mirrors state_q==IDLE but resets to 0 so req_ready stays low in reset
  // even when AUTO_INIT=0 parks the FSM in IDLE.
  assign req_ready = idle_q & ~init_start;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_d        = 1'b0;
    w_en_d      = 1'b0;
    op_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      INIT: begin
        // The counter names the address on the bus. Coming out of reset the bus
        // is still idle, so address 0 is issued before the counter advances.
        if (cs_q) begin
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      IDLE: begin
        if (idle_q && init_start) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (accept) begin
          state_d = req_write ? WRITE : READ;
          addr_d  = req_addr;
          if (req_write) begin
            wdata_d = req_wdata;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ:  state_d = RWAIT;
      RWAIT: begin
        // RAM sampled the read at the previous edge; data_out is valid now.
        state_d     = RESP;
        rsp_rdata_d = mem_rdata;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // RAM controls are registered from the next state so they line up with it.
    unique case (state_d)
      INIT: begin
        cs_d    = 1'b1;
        w_en_d  = 1'b1;
        addr_d  = cnt_d;
        wdata_d = INIT_VALUE;
      end
      WRITE: begin
        cs_d   = 1'b1;
        w_en_d = 1'b1;
      end
      READ: begin
        cs_d    = 1'b1;
        op_en_d = 1'b1;
      end
      // cs held high so the RAM keeps data_out instead of zeroing it.
      RWAIT:   cs_d = 1'b1;
      default: cs_d = 1'b0;
    endcase

    rsp_valid_d = (state_d == RESP);
    idle_d      = (state_d == IDLE);
    busy_d      = (state_d == INIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= AUTO_INIT ? INIT : IDLE;
      cnt_q       <= '0;
      cs_q        <= 1'b0;
      w_en_q      <= 1'b0;
      op_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      idle_q      <= 1'b0;
      busy_q      <= AUTO_INIT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      w_en_q      <= w_en_d;
      op_en_q     <= op_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      idle_q      <= idle_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_cs    = cs_q;
  assign mem_w_en  = w_en_q;
  assign mem_op_en = op_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_busy = busy_q;

endmodule

// File: tb/tb_ram16x8_master.sv
// tb_ram16x8_master: ram16x8_master driving a behavioural 16x8 synchronous RAM.
module tb_ram16x8_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready, req_write;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       init_start, init_busy;
  logic       mem_cs, mem_w_en, mem_op_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;
  int proto_err = 0;
  int rsp_cnt = 0;
  logic [3:0] wa[$];
  logic [7:0] wd[$];

  // RAM preload port (array is not cleared by reset)
  logic       ld_en;
  logic [3:0] ld_a;
  logic [7:0] ld_d;
  logic [7:0] ram [16];

  always #5 clk = ~clk;

  ram16x8_master #(.INIT_VALUE(8'h00), .AUTO_INIT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_start(init_start), .init_busy(init_busy),
    .mem_cs(mem_cs), .mem_w_en(mem_w_en), .mem_op_en(mem_op_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural RAM: registered data_out, zeroed while cs is low.
  always @(posedge clk) begin
    if (ld_en) ram[ld_a] <= ld_d;
    else if (reset_n && mem_cs && mem_w_en) ram[mem_addr] <= mem_wdata;
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_rdata <= 8'h00;
    else if (!mem_cs) mem_rdata <= 8'h00;
    else if (mem_op_en && !mem_w_en) mem_rdata <= ram[mem_addr];
  end

  // Bus monitor: write log, response count, protocol rules.
  always @(posedge clk) begin
    if (reset_n && mem_cs && mem_w_en) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (reset_n && rsp_valid) rsp_cnt++;
    if (mem_w_en && mem_op_en) proto_err++;
    if ((mem_w_en || mem_op_en) && !mem_cs) proto_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_sweep_done(input string nm);
    int n = 0;
    while (init_busy && n < 60) begin
      tick();
      n++;
    end
    if (init_busy) chk({nm, "_busy_timeout"}, 32'(init_busy), 32'd0);
  endtask

  task automatic check_sweep(input int start, input string nm);
    chk({nm, "_nwrites"}, 32'(wa.size() - start), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (start + i < wa.size())
        chk($sformatf("%s_w%0d", nm, i), 32'({wa[start+i], wd[start+i]}),
            32'({4'(i), 8'h00}));
    end
  endtask

  task automatic do_req(input logic wr, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] exp, input string nm);
    int n = 0;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    #1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    tick();  // E0: accept
    req_valid = 1'b0;
    if (wr) begin
      chk({nm, "_wr_bus"}, 32'({mem_cs, mem_w_en, mem_op_en, mem_addr, mem_wdata}),
          32'({3'b110, a, d}));
      tick();  // E1: RAM write
      chk({nm, "_wr_ready"}, 32'({req_ready, mem_cs}), 32'({1'b1, 1'b0}));
    end else begin
      chk({nm, "_rd_bus"}, 32'({mem_cs, mem_w_en, mem_op_en, mem_addr}),
          32'({3'b101, a}));
      tick();  // E1
      chk({nm, "_e1_valid"}, 32'({rsp_valid, mem_cs, mem_op_en}), 32'({1'b0, 1'b1, 1'b0}));
      tick();  // E2
      chk({nm, "_rdata"}, 32'({rsp_valid, rsp_rdata, req_ready}), 32'({1'b1, exp, 1'b0}));
      tick();  // E3: handshake with rsp_ready high
      chk({nm, "_done"}, 32'({rsp_valid, req_ready}), 32'({1'b0, 1'b1}));
    end
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    int start;
    int n;
    int r0;

    vt[0] = '{1'b0, 4'h7, 8'h00, 8'h00};
    vt[1] = '{1'b1, 4'h3, 8'hA5, 8'h00};
    vt[2] = '{1'b0, 4'h3, 8'h00, 8'hA5};
    vt[3] = '{1'b1, 4'hF, 8'h3C, 8'h00};
    vt[4] = '{1'b0, 4'hF, 8'h00, 8'h3C};
    vt[5] = '{1'b0, 4'h0, 8'h00, 8'h00};
    vt[6] = '{1'b1, 4'h0, 8'hFF, 8'h00};
    vt[7] = '{1'b0, 4'h0, 8'h00, 8'hFF};
    vt[8] = '{1'b0, 4'h3, 8'h00, 8'hA5};
    vt[9] = '{1'b1, 4'h9, 8'h96, 8'h00};

    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; init_start = 1'b0;
    ld_en = 1'b0; ld_a = '0; ld_d = '0;

    // Pre-load nonzero data while held in reset.
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1; ld_a = 4'(i); ld_d = 8'(8'hA0 + i);
      tick();
    end
    ld_en = 1'b0;
    chk("reset_outputs",
        32'({mem_cs, mem_w_en, mem_op_en, mem_addr, mem_wdata, rsp_valid, rsp_rdata, req_ready}),
        32'd0);
    chk("reset_busy", 32'(init_busy), 32'd1);

    // Power-up sweep.
    start = wa.size();
    @(negedge clk);
    reset_n = 1'b1;
    wait_sweep_done("sweep0");
    check_sweep(start, "sweep0");
    chk("sweep0_idle", 32'({mem_cs, req_ready}), 32'({1'b0, 1'b1}));

    // Directed request table.
    for (int i = 0; i < 10; i++)
      do_req(vt[i].wr, vt[i].a, vt[i].d, vt[i].exp, $sformatf("v%0d", i));

    // Response backpressure: read 9 with rsp_ready low for 5 cycles.
    rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = 4'h9; req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("bp_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("bp_first", 32'({rsp_valid, rsp_rdata}), 32'({1'b1, 8'h96}));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_hold%0d", k), 32'({rsp_valid, rsp_rdata, req_ready}),
          32'({1'b1, 8'h96, 1'b0}));
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_done", 32'({rsp_valid, req_ready}), 32'({1'b0, 1'b1}));

    // init_start beats a simultaneous write request.
    init_start = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h1; req_wdata = 8'h55;
    #1;
    chk("is_ready_low", 32'(req_ready), 32'd0);
    start = wa.size();
    tick();  // E0
    init_start = 1'b0;
    chk("is_first", 32'({init_busy, mem_cs, mem_w_en, mem_op_en, mem_addr, mem_wdata}),
        32'({4'b1110, 4'h0, 8'h00}));
    n = 0;
    while (init_busy && n < 40) begin
      n++;
      tick();
    end
    chk("is_busy_cycles", 32'(n), 32'd16);
    check_sweep(start, "is_sweep");
    chk("is_ready_after", 32'(req_ready), 32'd1);
    tick();
    chk("is_write", 32'({mem_cs, mem_w_en, mem_op_en, mem_addr, mem_wdata}),
        32'({3'b110, 4'h1, 8'h55}));
    req_valid = 1'b0;
    tick();
    do_req(1'b0, 4'h1, 8'h00, 8'h55, "is_rd1");
    do_req(1'b0, 4'h3, 8'h00, 8'h00, "is_rd3");

    // Reset during RWAIT.
    do_req(1'b1, 4'h5, 8'h77, 8'h00, "rw_wr5");
    req_write = 1'b0; req_addr = 4'h5; req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    tick();  // E0
    req_valid = 1'b0;
    tick();  // E1: RWAIT
    chk("rw_in_rwait", 32'({mem_cs, mem_w_en, mem_op_en, rsp_valid}), 32'({4'b1000}));
    r0 = rsp_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rw_reset_outputs",
        32'({mem_cs, mem_w_en, mem_op_en, mem_addr, mem_wdata, rsp_valid, rsp_rdata, req_ready}),
        32'd0);
    chk("rw_reset_busy", 32'(init_busy), 32'd1);
    tick();
    tick();
    start = wa.size();
    @(negedge clk);
    reset_n = 1'b1;
    wait_sweep_done("sweep1");
    check_sweep(start, "sweep1");
    chk("rw_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    do_req(1'b0, 4'h5, 8'h00, 8'h00, "rw_rd5");

    chk("protocol", 32'(proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
